// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run sequencer for the MIPS core (reset, start, pause, abort, watchdog)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle run request, ignored while busy
//   hold         level, pauses the core while running
//   abort        one-cycle request to end the run (honoured in HOLD_RST and RUN)
//   cpu_stopped  core reports it has halted
//   cpu_rst_n    active-low reset to the core
//   cpu_run      core clock-enable
//   busy         high from accepted start until done drops
//   done         one-cycle completion pulse
//   status       00 halted, 01 aborted, 10 watchdog
//   cycle_count  cycles cpu_run was high in the current/last run (saturating)
//
// Build option: define CPU_RUN_WATCHDOG_EN to enable the WDOG_LIMIT watchdog.
module cpu_run_ctrl #(
    parameter int CYCLE_W    = 32,
    parameter int RST_CYCLES = 4,
    parameter int WDOG_LIMIT = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               hold,
    input  logic               abort,
    input  logic               cpu_stopped,
    output logic               cpu_rst_n,
    output logic               cpu_run,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [CYCLE_W-1:0] cycle_count
);
    typedef enum logic [1:0] {IDLE, HOLD_RST, RUN, DONE} state_t;

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_ABORT = 2'b01;
    localparam logic [1:0] ST_WDOG  = 2'b10;

    state_t             state;
    logic [7:0]         rcnt;
    logic [CYCLE_W-1:0] cnt_inc;
    logic               sat;
    logic               wdog_hit;

    assign cnt_inc = cycle_count + 1'b1;
    assign sat     = &cycle_count;

`ifdef CPU_RUN_WATCHDOG_EN
    // Fires on the edge where the count would reach the limit, so the final value equals it.
    assign wdog_hit = cpu_run && !sat && (cnt_inc == CYCLE_W'(WDOG_LIMIT));
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = |WDOG_LIMIT;
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rcnt        <= '0;
            cpu_rst_n   <= 1'b0;
            cpu_run     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            status      <= ST_HALT;
            cycle_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= HOLD_RST;
                    busy        <= 1'b1;
                    cpu_rst_n   <= 1'b0;
                    cpu_run     <= 1'b0;
                    status      <= ST_HALT;
                    cycle_count <= '0;
                    rcnt        <= 8'(RST_CYCLES);
                end
                HOLD_RST: begin
                    // An abort here leaves the core held in reset.
                    if (abort) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        status <= ST_ABORT;
                    end else if (rcnt == 8'd1) begin
                        state     <= RUN;
                        cpu_rst_n <= 1'b1;
                        cpu_run   <= 1'b1;
                    end else begin
                        rcnt <= rcnt - 8'd1;
                    end
                end
                RUN: begin
                    // The cycle in which an exit is sampled still counts if the core ran.
                    if (cpu_run && !sat)
                        cycle_count <= cnt_inc;
                    if (abort || cpu_stopped || wdog_hit) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpu_run <= 1'b0;
                        status  <= abort ? ST_ABORT : cpu_stopped ? ST_HALT : ST_WDOG;
                    end else begin
                        cpu_run <= !hold;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: randomized self-checking bench for cpu_run_ctrl against a run-level model
module tb_cpu_run_ctrl;
    localparam int CW = 32;
    localparam int RC = 4;
    localparam int WL = 20;
`ifdef CPU_RUN_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          abort = 1'b0;
    logic          cpu_stopped = 1'b0;
    logic          cpu_rst_n;
    logic          cpu_run;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] cycle_count;
    int            total = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.CYCLE_W(CW), .RST_CYCLES(RC), .WDOG_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .abort(abort),
        .cpu_stopped(cpu_stopped), .cpu_rst_n(cpu_rst_n), .cpu_run(cpu_run),
        .busy(busy), .done(done), .status(status), .cycle_count(cycle_count)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done, status} !== 6'b0 || cycle_count !== '0)
            $display("FAIL reset_async got ctl=%b cnt=%0d want ctl=000000 cnt=0", {cpu_rst_n, cpu_run, busy, done, status}, cycle_count);
        else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done, status} !== 6'b0 || cycle_count !== '0)
            $display("FAIL reset_idle got ctl=%b cnt=%0d want ctl=000000 cnt=0", {cpu_rst_n, cpu_run, busy, done, status}, cycle_count);
        else passed++;
    endtask

    // One complete run. The model treats the core as executing whenever enabled; it stops
    // once it has executed stop_after cycles. abort_at is the RUN cycle index (1-based) of an abort.
    task automatic do_run(input string name, input int stop_after, input int abort_at,
                          input int hold_from, input int hold_len, input bit rnd, input bit start_in_done);
        int       exp_cnt;
        bit       exp_run;
        bit       ex;
        int       idx;
        logic [1:0] est;
        start = 1'b1;
        step;
        start = 1'b0;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done} !== 4'b0010 || status !== 2'b00 || cycle_count !== '0)
            $display("FAIL %s_start got ctl=%b st=%b cnt=%0d want ctl=0010 st=00 cnt=0", name, {cpu_rst_n, cpu_run, busy, done}, status, cycle_count);
        else passed++;
        for (int i = 1; i < RC; i++) begin
            step;
            total++;
            if ({cpu_rst_n, cpu_run, busy, done} !== 4'b0010)
                $display("FAIL %s_hold_rst%0d got ctl=%b want ctl=0010", name, i, {cpu_rst_n, cpu_run, busy, done});
            else passed++;
        end
        step;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done} !== 4'b1110 || cycle_count !== '0)
            $display("FAIL %s_run_entry got ctl=%b cnt=%0d want ctl=1110 cnt=0", name, {cpu_rst_n, cpu_run, busy, done}, cycle_count);
        else passed++;
        exp_cnt = 0;
        exp_run = 1'b1;
        ex = 1'b0;
        idx = 0;
        est = 2'b00;
        while (!ex && idx < 300) begin
            idx++;
            hold = (hold_len > 0 && idx >= hold_from && idx < hold_from + hold_len) || (rnd && $urandom_range(3) == 0);
            abort = (idx == abort_at);
            cpu_stopped = exp_run && (exp_cnt + 1 >= stop_after);
            start = rnd && $urandom_range(5) == 0;
            if (abort) begin est = 2'b01; ex = 1'b1; end
            else if (cpu_stopped) begin est = 2'b00; ex = 1'b1; end
            else if (WD && exp_run && exp_cnt + 1 == WL) begin est = 2'b10; ex = 1'b1; end
            exp_cnt += int'(exp_run);
            exp_run = !ex && !hold;
            step;
            {hold, abort, cpu_stopped, start} = 4'b0;
            if (!ex) begin
                total++;
                if ({cpu_rst_n, cpu_run, busy, done} !== {1'b1, exp_run, 2'b10} || cycle_count !== CW'(exp_cnt))
                    $display("FAIL %s_run_c%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d", name, idx, {cpu_rst_n, cpu_run, busy, done}, cycle_count, {1'b1, exp_run, 2'b10}, exp_cnt);
                else passed++;
            end
        end
        if (!ex) begin
            total++;
            $display("FAIL %s_timeout got no exit after %0d cycles want exit", name, idx);
            rst_n = 1'b0;
            #2 rst_n = 1'b1;
            return;
        end
        total++;
        if ({cpu_rst_n, cpu_run, busy, done} !== 4'b1011 || status !== est || cycle_count !== CW'(exp_cnt))
            $display("FAIL %s_done got ctl=%b st=%b cnt=%0d want ctl=1011 st=%b cnt=%0d", name, {cpu_rst_n, cpu_run, busy, done}, status, cycle_count, est, exp_cnt);
        else passed++;
        start = start_in_done;
        step;
        start = 1'b0;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done} !== 4'b1000 || status !== est || cycle_count !== CW'(exp_cnt))
            $display("FAIL %s_idle got ctl=%b st=%b cnt=%0d want ctl=1000 st=%b cnt=%0d", name, {cpu_rst_n, cpu_run, busy, done}, status, cycle_count, est, exp_cnt);
        else passed++;
    endtask

    task automatic test_halt;
        do_run("halt", 10, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_hold;
        do_run("hold", 10, 0, 4, 5, 1'b0, 1'b0);
    endtask

    task automatic test_abort_vs_stop;
        do_run("abort_stop", 3, 3, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_watchdog;
        do_run("wdog", 1000, WD ? 0 : 40, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_run("b2b_a", 6, 0, 0, 0, 1'b1, 1'b1);
        do_run("b2b_b", 4, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort_hold_rst;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        abort = 1'b1;
        step;
        abort = 1'b0;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done} !== 4'b0011 || status !== 2'b01 || cycle_count !== '0)
            $display("FAIL abort_hold_rst got ctl=%b st=%b cnt=%0d want ctl=0011 st=01 cnt=0", {cpu_rst_n, cpu_run, busy, done}, status, cycle_count);
        else passed++;
        step;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done} !== 4'b0000 || status !== 2'b01)
            $display("FAIL abort_hold_rst_idle got ctl=%b st=%b want ctl=0000 st=01", {cpu_rst_n, cpu_run, busy, done}, status);
        else passed++;
    endtask

    task automatic test_idle_ignores;
        abort = 1'b1;
        cpu_stopped = 1'b1;
        hold = 1'b1;
        step;
        {abort, cpu_stopped, hold} = 3'b0;
        step;
        total++;
        if ({busy, done, status} !== 4'b0001)
            $display("FAIL idle_ignore got busy_done_st=%b want 0001", {busy, done, status});
        else passed++;
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++)
            do_run($sformatf("rnd%0d", r), $urandom_range(1, 15),
                   $urandom_range(1) ? $urandom_range(1, 18) : 0, 0, 0, 1'b1, 1'(r & 1));
    endtask

    task automatic test_reset_midrun;
        logic seen_done;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (RC + 3) step;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cpu_rst_n, cpu_run, busy, done, status} !== 6'b0 || cycle_count !== '0)
            $display("FAIL reset_midrun got ctl=%b cnt=%0d want ctl=000000 cnt=0", {cpu_rst_n, cpu_run, busy, done, status}, cycle_count);
        else passed++;
        step;
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (6) begin
            step;
            seen_done |= done | busy;
        end
        total++;
        if (seen_done !== 1'b0)
            $display("FAIL reset_no_done got done_or_busy=%b want 0", seen_done);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_halt;
        test_hold;
        test_abort_vs_stop;
        test_watchdog;
        test_abort_hold_rst;
        test_idle_ignores;
        test_back_to_back;
        test_random;
        test_reset_midrun;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
